beep_tone_ctrl: RTL and testbench



---
 rtl/beep_pkg.sv | 30 +++
 rtl/beep_tone_gen.sv | 38 +++
 rtl/beep_tone_ctrl.sv | 147 ++++++++++++++
 tb/tb_beep_tone_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and default timing constants for the buzzer tone sequencer.
// Defaults assume a 50 MHz clock.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int HALF_W = 17;
    localparam int CNT_W  = 24;

    localparam int unsigned HALF_P0_DEF = 95_420;
    localparam int unsigned HALF_P1_DEF = 85_034;
    localparam int unsigned HALF_P2_DEF = 75_758;
    localparam int unsigned HALF_P3_DEF = 71_633;
    localparam int unsigned DUR_CNT_DEF = 5_000_000;
    localparam int unsigned GAP_CNT_DEF = 500_000;

    function automatic logic [1:0] lowest_idx(input logic [3:0] k);
        logic [1:0] idx;
        if (k[0])      idx = 2'd0;
        else if (k[1]) idx = 2'd1;
        else if (k[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave generator: load starts high with a cleared count, en toggles every half cycles.
// Any cycle without en or load forces the output low and clears the count.
module beep_tone_gen
    import beep_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              load,
    input  logic [HALF_W-1:0] half,
    output logic              beep
);

    localparam logic [HALF_W-1:0] HALF_ONE = HALF_W'(1);

    logic [HALF_W-1:0] half_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            half_cnt <= '0;
            beep     <= 1'b0;
        end else if (load) begin
            half_cnt <= '0;
            beep     <= 1'b1;
        end else if (en) begin
            if (half_cnt == half - HALF_ONE) begin
                half_cnt <= '0;
                beep     <= ~beep;
            end else begin
                half_cnt <= half_cnt + HALF_ONE;
            end
        end else begin
            half_cnt <= '0;
            beep     <= 1'b0;
        end
    end

endmodule

// File: rtl/beep_tone_ctrl.sv
// Key-pulse to buzzer tone sequencer: IDLE -> TONE (DUR_CNT cycles) -> GAP (GAP_CNT cycles); outputs valid the edge after an accepted pulse.
// No backpressure: pulses outside IDLE are dropped, or held in a 1-entry pending slot when BEEP_QUEUE_EN is defined.
module beep_tone_ctrl
    import beep_pkg::*;
#(
    parameter int unsigned HALF_P0 = HALF_P0_DEF,
    parameter int unsigned HALF_P1 = HALF_P1_DEF,
    parameter int unsigned HALF_P2 = HALF_P2_DEF,
    parameter int unsigned HALF_P3 = HALF_P3_DEF,
    parameter int unsigned DUR_CNT = DUR_CNT_DEF,
    parameter int unsigned GAP_CNT = GAP_CNT_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] key_pulse,
    output logic       beep,
    output logic       busy,
    output logic [1:0] key_id
);

    localparam logic [HALF_W-1:0] H0       = HALF_W'(HALF_P0);
    localparam logic [HALF_W-1:0] H1       = HALF_W'(HALF_P1);
    localparam logic [HALF_W-1:0] H2       = HALF_W'(HALF_P2);
    localparam logic [HALF_W-1:0] H3       = HALF_W'(HALF_P3);
    localparam logic [CNT_W-1:0]  DUR_LAST = CNT_W'(DUR_CNT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  dur_cnt, dur_n;
    logic [CNT_W-1:0]  gap_cnt, gap_n;
    logic [1:0]        key_id_n;
    logic              busy_n;
    logic              load;
    logic              en;
    logic [HALF_W-1:0] half;

`ifdef BEEP_QUEUE_EN
    logic       pend_vld, pend_vld_n;
    logic [1:0] pend_idx, pend_idx_n;
`endif

    // key_id is registered and stable for the whole tone, so it selects the pitch directly
    always_comb begin
        case (key_id)
            2'd0:    half = H0;
            2'd1:    half = H1;
            2'd2:    half = H2;
            default: half = H3;
        endcase
    end

    always_comb begin
        state_n  = state;
        dur_n    = dur_cnt;
        gap_n    = gap_cnt;
        key_id_n = key_id;
        load     = 1'b0;
        en       = 1'b0;
`ifdef BEEP_QUEUE_EN
        pend_vld_n = pend_vld;
        pend_idx_n = pend_idx;
        if (state != IDLE && (|key_pulse) && !pend_vld) begin
            pend_vld_n = 1'b1;
            pend_idx_n = lowest_idx(key_pulse);
        end
`endif
        case (state)
            IDLE: begin
                if (|key_pulse) begin
                    state_n  = TONE;
                    key_id_n = lowest_idx(key_pulse);
                    dur_n    = '0;
                    gap_n    = '0;
                    load     = 1'b1;
                end
            end
            TONE: begin
                // en is withheld on the last cycle so the generator drops beep on entry to GAP
                if (dur_cnt == DUR_LAST) begin
                    state_n = GAP;
                    gap_n   = '0;
                end else begin
                    dur_n = dur_cnt + CNT_ONE;
                    en    = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
`ifdef BEEP_QUEUE_EN
                    // a pulse landing on the final GAP cycle counts as a queued press
                    if (pend_vld || (|key_pulse)) begin
                        state_n    = TONE;
                        key_id_n   = pend_vld ? pend_idx : lowest_idx(key_pulse);
                        dur_n      = '0;
                        gap_n      = '0;
                        load       = 1'b1;
                        pend_vld_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end else begin
                    gap_n = gap_cnt + CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            dur_cnt <= '0;
            gap_cnt <= '0;
            key_id  <= 2'd0;
            busy    <= 1'b0;
`ifdef BEEP_QUEUE_EN
            pend_vld <= 1'b0;
            pend_idx <= 2'd0;
`endif
        end else begin
            state   <= state_n;
            dur_cnt <= dur_n;
            gap_cnt <= gap_n;
            key_id  <= key_id_n;
            busy    <= busy_n;
`ifdef BEEP_QUEUE_EN
            pend_vld <= pend_vld_n;
            pend_idx <= pend_idx_n;
`endif
        end
    end

    beep_tone_gen u_tone_gen (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .load (load),
        .half (half),
        .beep (beep)
    );

endmodule

// File: tb/tb_beep_tone_ctrl.sv
// Directed bench for beep_tone_ctrl with short simulation timings.
module tb_beep_tone_ctrl;

    localparam int DUR = 40;
    localparam int GAP = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [3:0] key_pulse = 4'b0;
    logic       beep;
    logic       busy;
    logic [1:0] key_id;

    int checks = 0;
    int failures = 0;

    logic [119:0] act_beep;
    logic [119:0] act_busy;
    logic [1:0]   kid0;

    always #5 clk = ~clk;

    beep_tone_ctrl #(
        .HALF_P0 (4),
        .HALF_P1 (5),
        .HALF_P2 (6),
        .HALF_P3 (7),
        .DUR_CNT (DUR),
        .GAP_CNT (GAP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .key_pulse (key_pulse),
        .beep      (beep),
        .busy      (busy),
        .key_id    (key_id)
    );

    // Expected beep bits for a tone of half-period h starting at cycle start.
    function automatic logic [119:0] tone_wave(input int h, input int start);
        logic [119:0] w;
        w = '0;
        for (int c = 0; c < DUR; c++)
            if (((c / h) % 2) == 0) w[start + c] = 1'b1;
        return w;
    endfunction

    function automatic logic [119:0] span(input int start, input int len);
        logic [119:0] w;
        w = '0;
        for (int c = 0; c < len; c++) w[start + c] = 1'b1;
        return w;
    endfunction

    // Pulse is sampled at the following posedge; returns in cycle 0 of the tone.
    task automatic start_key(input logic [3:0] k);
        @(negedge clk);
        key_pulse = k;
        @(negedge clk);
        key_pulse = 4'b0;
    endtask

    // Samples n cycles from cycle 0; optionally drives inj_key during cycle inj_at.
    task automatic record(input int n, input int inj_at, input logic [3:0] inj_key);
        act_beep = '0;
        act_busy = '0;
        for (int i = 0; i < n; i++) begin
            act_beep[i] = beep;
            act_busy[i] = busy;
            if (i == 0) kid0 = key_id;
            key_pulse = (i == inj_at) ? inj_key : 4'b0;
            @(negedge clk);
        end
        key_pulse = 4'b0;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (beep !== 1'b0) begin failures++; $display("FAIL reset_beep got=%b want=0", beep); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (key_id !== 2'd0) begin failures++; $display("FAIL reset_key_id got=%0d want=0", key_id); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_key0();
        logic [119:0] eb, ey;
        start_key(4'b0001);
        record(60, -1, 4'b0);
        eb = tone_wave(4, 0);
        ey = span(0, 50);
        checks++;
        if (act_beep !== eb) begin failures++; $display("FAIL key0_beep got=%h want=%h", act_beep, eb); end
        checks++;
        if (act_busy !== ey) begin failures++; $display("FAIL key0_busy got=%h want=%h", act_busy, ey); end
        checks++;
        if (kid0 !== 2'd0) begin failures++; $display("FAIL key0_id got=%0d want=0", kid0); end
    endtask

    task automatic test_lowest_wins();
        logic [119:0] eb, ey;
        start_key(4'b1100);
        record(60, -1, 4'b0);
        eb = tone_wave(6, 0);
        ey = span(0, 50);
        checks++;
        if (act_beep !== eb) begin failures++; $display("FAIL multi_beep got=%h want=%h", act_beep, eb); end
        checks++;
        if (act_busy !== ey) begin failures++; $display("FAIL multi_busy got=%h want=%h", act_busy, ey); end
        checks++;
        if (kid0 !== 2'd2) begin failures++; $display("FAIL multi_id got=%0d want=2", kid0); end
    endtask

    task automatic test_pulse_in_tone();
        logic [119:0] eb, ey;
        logic [1:0]   ek;
        start_key(4'b0010);
        record(110, 20, 4'b1000);
`ifdef BEEP_QUEUE_EN
        eb = tone_wave(5, 0) | tone_wave(7, 50);
        ey = span(0, 100);
        ek = 2'd3;
`else
        eb = tone_wave(5, 0);
        ey = span(0, 50);
        ek = 2'd1;
`endif
        checks++;
        if (act_beep !== eb) begin failures++; $display("FAIL in_tone_beep got=%h want=%h", act_beep, eb); end
        checks++;
        if (act_busy !== ey) begin failures++; $display("FAIL in_tone_busy got=%h want=%h", act_busy, ey); end
        checks++;
        if (key_id !== ek) begin failures++; $display("FAIL in_tone_id got=%0d want=%0d", key_id, ek); end
    endtask

    task automatic test_gap_edge();
        logic [119:0] eb, ey;
        logic [1:0]   ek;
        start_key(4'b0001);
        record(110, 49, 4'b0010);
`ifdef BEEP_QUEUE_EN
        eb = tone_wave(4, 0) | tone_wave(5, 50);
        ey = span(0, 100);
        ek = 2'd1;
`else
        eb = tone_wave(4, 0);
        ey = span(0, 50);
        ek = 2'd0;
`endif
        checks++;
        if (act_beep !== eb) begin failures++; $display("FAIL gap_edge_beep got=%h want=%h", act_beep, eb); end
        checks++;
        if (act_busy !== ey) begin failures++; $display("FAIL gap_edge_busy got=%h want=%h", act_busy, ey); end
        checks++;
        if (key_id !== ek) begin failures++; $display("FAIL gap_edge_id got=%0d want=%0d", key_id, ek); end
    endtask

    task automatic test_back_to_back();
        logic [119:0] eb, ey;
        logic [1:0]   ek;
        start_key(4'b0001);
        record(110, 1, 4'b0100);
`ifdef BEEP_QUEUE_EN
        eb = tone_wave(4, 0) | tone_wave(6, 50);
        ey = span(0, 100);
        ek = 2'd2;
`else
        eb = tone_wave(4, 0);
        ey = span(0, 50);
        ek = 2'd0;
`endif
        checks++;
        if (act_beep !== eb) begin failures++; $display("FAIL b2b_beep got=%h want=%h", act_beep, eb); end
        checks++;
        if (act_busy !== ey) begin failures++; $display("FAIL b2b_busy got=%h want=%h", act_busy, ey); end
        checks++;
        if (key_id !== ek) begin failures++; $display("FAIL b2b_id got=%0d want=%0d", key_id, ek); end
    endtask

    task automatic test_reset_mid_tone();
        logic [119:0] eb, ey;
        start_key(4'b0100);
        record(15, -1, 4'b0);
        eb = tone_wave(6, 0) & span(0, 15);
        ey = span(0, 15);
        checks++;
        if (act_beep !== eb) begin failures++; $display("FAIL pre_rst_beep got=%h want=%h", act_beep, eb); end
        checks++;
        if (act_busy !== ey) begin failures++; $display("FAIL pre_rst_busy got=%h want=%h", act_busy, ey); end
        rstn = 1'b0;
        #1;
        checks++;
        if (beep !== 1'b0) begin failures++; $display("FAIL mid_rst_beep got=%b want=0", beep); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        checks++;
        if (key_id !== 2'd0) begin failures++; $display("FAIL mid_rst_id got=%0d want=0", key_id); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        start_key(4'b0010);
        record(60, -1, 4'b0);
        eb = tone_wave(5, 0);
        ey = span(0, 50);
        checks++;
        if (act_beep !== eb) begin failures++; $display("FAIL post_rst_beep got=%h want=%h", act_beep, eb); end
        checks++;
        if (act_busy !== ey) begin failures++; $display("FAIL post_rst_busy got=%h want=%h", act_busy, ey); end
        checks++;
        if (kid0 !== 2'd1) begin failures++; $display("FAIL post_rst_id got=%0d want=1", kid0); end
    endtask

    initial begin
        test_reset();
        test_key0();
        test_lowest_wins();
        test_pulse_in_tone();
        test_gap_edge();
        test_back_to_back();
        test_reset_mid_tone();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
